// File: rtl/reg_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU/LSU writebacks onto the single
// write port and keeps per-register busy bits that stall issue on RAW/WAW hazards.
module reg_wb_scheduler #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int REG_MEM_DEPTH_POW  = 5
) (
    input  logic                                 clk_in,
    input  logic                                 reset_n,
    input  logic                                 issue_valid,
    input  logic                                 issue_uses_rd,
    input  logic [REG_MEM_DEPTH_POW-1:0]         issue_rs1,
    input  logic [REG_MEM_DEPTH_POW-1:0]         issue_rs2,
    input  logic [REG_MEM_DEPTH_POW-1:0]         issue_rd,
    output logic                                 issue_ready,
    input  logic                                 alu_valid,
    input  logic [REG_MEM_DEPTH_POW-1:0]         alu_rd,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]   alu_data,
    output logic                                 alu_ready,
    input  logic                                 lsu_valid,
    input  logic [REG_MEM_DEPTH_POW-1:0]         lsu_rd,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]   lsu_data,
    output logic                                 lsu_ready,
    output logic                                 wr_en_out,
    output logic [REG_MEM_DEPTH_POW-1:0]         wr_rd_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0]   wr_data_out,
    output logic [(1<<REG_MEM_DEPTH_POW)-1:0]    busy_out,
    output logic                                 err_out
);

    localparam int W = 1 << REG_DATA_WIDTH_POW;
    localparam int A = REG_MEM_DEPTH_POW;
    localparam int N = 1 << REG_MEM_DEPTH_POW;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

    // Handshake: a writeback transfers on the edge where valid & ready are both high;
    // requesters keep valid/rd/data stable until that edge and never drop valid early.

    prio_e          prio_q, prio_d;
    logic [N-1:0]   busy_q, busy_d;
    logic           wr_en_q, wr_en_d;
    logic [A-1:0]   wr_rd_q, wr_rd_d;
    logic [W-1:0]   wr_data_q, wr_data_d;
    logic           err_q, err_d;

    logic           alu_gnt;
    logic           lsu_gnt;
    logic           hazard_free;
    logic           issue_fire;
    logic [A-1:0]   sel_rd;
    logic [W-1:0]   sel_data;

    always_comb begin
        hazard_free = !busy_q[issue_rs1] && !busy_q[issue_rs2]
                      && !(issue_uses_rd && busy_q[issue_rd]);
        issue_ready = reset_n && hazard_free;
        issue_fire  = issue_valid && issue_ready;
    end

    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        prio_d  = prio_q;
        if (reset_n) begin
            if (alu_valid && (!lsu_valid || prio_q == PRIO_ALU)) begin
                alu_gnt = 1'b1;
            end else if (lsu_valid) begin
                lsu_gnt = 1'b1;
            end
            // Only a contested grant hands priority to the loser.
            if (alu_valid && lsu_valid) begin
                prio_d = alu_gnt ? PRIO_LSU : PRIO_ALU;
            end
        end
        alu_ready = alu_gnt;
        lsu_ready = lsu_gnt;
    end

    always_comb begin
        sel_rd    = alu_gnt ? alu_rd : lsu_rd;
        sel_data  = alu_gnt ? alu_data : lsu_data;
        wr_en_d   = 1'b0;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        if (alu_gnt || lsu_gnt) begin
            wr_en_d   = (sel_rd != '0);
            wr_rd_d   = sel_rd;
            wr_data_d = sel_data;
        end
    end

    // Clear lands on the same edge the regfile commits, so readers never need a bypass;
    // a same-edge issue to that register re-sets the bit after the clear.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (wr_en_q) begin
            busy_d[wr_rd_q] = 1'b0;
            if (!busy_q[wr_rd_q]) begin
                err_d = 1'b1;
            end
        end
        if (issue_fire && issue_uses_rd && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            prio_q    <= PRIO_ALU;
            busy_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign wr_en_out   = wr_en_q;
    assign wr_rd_out   = wr_rd_q;
    assign wr_data_out = wr_data_q;
    assign busy_out    = busy_q;
    assign err_out     = err_q;

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed bench for reg_wb_scheduler: reset, hazard stall/clear, contested arbitration,
// x0 writeback, stray-writeback error and same-edge set/clear.
module tb_reg_wb_scheduler;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_uses_rd = 1'b0;
    logic [4:0]  issue_rs1 = '0;
    logic [4:0]  issue_rs2 = '0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [63:0] alu_data = '0;
    logic        alu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [63:0] lsu_data = '0;
    logic        lsu_ready;
    logic        wr_en_out;
    logic [4:0]  wr_rd_out;
    logic [63:0] wr_data_out;
    logic [31:0] busy_out;
    logic        err_out;

    int n_cmp = 0;
    int n_fail = 0;

    reg_wb_scheduler #(.REG_DATA_WIDTH_POW(6), .REG_MEM_DEPTH_POW(5)) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_uses_rd(issue_uses_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .wr_en_out(wr_en_out), .wr_rd_out(wr_rd_out), .wr_data_out(wr_data_out),
        .busy_out(busy_out), .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    // Advance to 1ns after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd0; lsu_rd = 5'd0;
        issue_valid = 1'b1; issue_uses_rd = 1'b1; issue_rd = 5'd5;
        #1;
        n_cmp++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready got %b want 0", alu_ready); end
        n_cmp++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_ready got %b want 0", lsu_ready); end
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_issue_ready got %b want 0", issue_ready); end
        n_cmp++; if (busy_out !== 32'h0) begin n_fail++; $display("FAIL rst_busy got %h want 0", busy_out); end
        n_cmp++; if ({wr_en_out, wr_rd_out, wr_data_out, err_out} !== 71'h0) begin
            n_fail++; $display("FAIL rst_wr_port got en=%b rd=%0d data=%h err=%b want all 0",
                               wr_en_out, wr_rd_out, wr_data_out, err_out);
        end
        step(); step();
        reset_n = 1'b1;
        #1;
        n_cmp++; if ({alu_ready, lsu_ready} !== 2'b10) begin n_fail++; $display("FAIL rst_prio_alu got %b want 10", {alu_ready, lsu_ready}); end
        n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_issue_after got %b want 1", issue_ready); end
        step();
        n_cmp++; if (busy_out !== 32'h0000_0020) begin n_fail++; $display("FAIL rst_busy5 got %h want 00000020", busy_out); end
        n_cmp++; if ({alu_ready, lsu_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_prio_toggle got %b want 01", {alu_ready, lsu_ready}); end
        issue_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (busy_out !== 32'h0) begin n_fail++; $display("FAIL rst_mid_busy got %h want 0", busy_out); end
        n_cmp++; if ({alu_ready, lsu_ready, wr_en_out} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_outs got %b want 000", {alu_ready, lsu_ready, wr_en_out});
        end
        step();
        reset_n = 1'b1;
        #1;
        n_cmp++; if ({alu_ready, lsu_ready} !== 2'b10) begin n_fail++; $display("FAIL rst_prio_restored got %b want 10", {alu_ready, lsu_ready}); end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        step();
    endtask

    task automatic test_raw_hazard();
        issue_valid = 1'b1; issue_uses_rd = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd5;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_ready_free got %b want 1", issue_ready); end
        step();
        n_cmp++; if (busy_out !== 32'h0000_0020) begin n_fail++; $display("FAIL raw_busy_set got %h want 00000020", busy_out); end
        issue_rs1 = 5'd5; issue_rd = 5'd6;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
        #1;
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall got %b want 0", issue_ready); end
        n_cmp++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL raw_alu_grant got %b want 1", alu_ready); end
        step();
        alu_valid = 1'b0;
        n_cmp++; if ({wr_en_out, wr_rd_out} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL raw_wr got en=%b rd=%0d want en=1 rd=5", wr_en_out, wr_rd_out); end
        n_cmp++; if (wr_data_out !== 64'hDEAD) begin n_fail++; $display("FAIL raw_wr_data got %h want dead", wr_data_out); end
        n_cmp++; if (busy_out !== 32'h0000_0020) begin n_fail++; $display("FAIL raw_busy_hold got %h want 00000020", busy_out); end
        n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_hold got %b want 0", issue_ready); end
        step();
        n_cmp++; if (busy_out !== 32'h0) begin n_fail++; $display("FAIL raw_busy_clear got %h want 0", busy_out); end
        n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_ready_back got %b want 1", issue_ready); end
        n_cmp++; if ({wr_en_out, err_out} !== 2'b00) begin n_fail++; $display("FAIL raw_after got en/err=%b want 00", {wr_en_out, err_out}); end
        issue_valid = 1'b0; issue_rs1 = 5'd0;
        step();
    endtask

    task automatic test_arbitration();
        issue_valid = 1'b1; issue_uses_rd = 1'b1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd4;
        step();
        issue_valid = 1'b0;
        n_cmp++; if (busy_out !== 32'h0000_0018) begin n_fail++; $display("FAIL arb_busy_pre got %h want 00000018", busy_out); end
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA3;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'hB4;
        #1;
        n_cmp++; if ({alu_ready, lsu_ready} !== 2'b10) begin n_fail++; $display("FAIL arb_g0 got %b want 10", {alu_ready, lsu_ready}); end
        step();
        n_cmp++; if ({wr_en_out, wr_rd_out, wr_data_out} !== {1'b1, 5'd3, 64'hA3}) begin
            n_fail++; $display("FAIL arb_w0 got en=%b rd=%0d data=%h want 1/3/a3", wr_en_out, wr_rd_out, wr_data_out);
        end
        n_cmp++; if ({alu_ready, lsu_ready} !== 2'b01) begin n_fail++; $display("FAIL arb_g1 got %b want 01", {alu_ready, lsu_ready}); end
        step();
        n_cmp++; if ({wr_en_out, wr_rd_out, wr_data_out} !== {1'b1, 5'd4, 64'hB4}) begin
            n_fail++; $display("FAIL arb_w1 got en=%b rd=%0d data=%h want 1/4/b4", wr_en_out, wr_rd_out, wr_data_out);
        end
        n_cmp++; if (busy_out !== 32'h0000_0010) begin n_fail++; $display("FAIL arb_busy1 got %h want 00000010", busy_out); end
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        n_cmp++; if ({alu_ready, lsu_ready, issue_ready} !== 3'b101) begin n_fail++; $display("FAIL arb_g2 got %b want 101", {alu_ready, lsu_ready, issue_ready}); end
        step();
        n_cmp++; if ({wr_en_out, wr_rd_out} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL arb_w2 got en=%b rd=%0d want 1/3", wr_en_out, wr_rd_out); end
        n_cmp++; if (busy_out !== 32'h0000_0008) begin n_fail++; $display("FAIL arb_busy2 got %h want 00000008", busy_out); end
        issue_rd = 5'd4;
        #1;
        n_cmp++; if ({alu_ready, lsu_ready, issue_ready} !== 3'b011) begin n_fail++; $display("FAIL arb_g3 got %b want 011", {alu_ready, lsu_ready, issue_ready}); end
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        n_cmp++; if ({wr_en_out, wr_rd_out} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL arb_w3 got en=%b rd=%0d want 1/4", wr_en_out, wr_rd_out); end
        n_cmp++; if (busy_out !== 32'h0000_0010) begin n_fail++; $display("FAIL arb_busy3 got %h want 00000010", busy_out); end
        step();
        n_cmp++; if ({busy_out, wr_en_out, err_out} !== 34'h0) begin
            n_fail++; $display("FAIL arb_end got busy=%h en=%b err=%b want 0/0/0", busy_out, wr_en_out, err_out);
        end
    endtask

    task automatic test_x0_writeback();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hFF;
        issue_valid = 1'b1; issue_uses_rd = 1'b1; issue_rd = 5'd0;
        #1;
        n_cmp++; if ({alu_ready, lsu_ready, issue_ready} !== 3'b011) begin n_fail++; $display("FAIL x0_ready got %b want 011", {alu_ready, lsu_ready, issue_ready}); end
        step();
        lsu_valid = 1'b0; issue_valid = 1'b0;
        n_cmp++; if (wr_en_out !== 1'b0) begin n_fail++; $display("FAIL x0_no_write got %b want 0", wr_en_out); end
        n_cmp++; if ({wr_rd_out, wr_data_out} !== {5'd0, 64'hFF}) begin n_fail++; $display("FAIL x0_port got rd=%0d data=%h want 0/ff", wr_rd_out, wr_data_out); end
        n_cmp++; if (busy_out !== 32'h0) begin n_fail++; $display("FAIL x0_busy got %h want 0", busy_out); end
        step();
        n_cmp++; if ({err_out, wr_en_out} !== 2'b00) begin n_fail++; $display("FAIL x0_err got err/en=%b want 00", {err_out, wr_en_out}); end
    endtask

    task automatic test_stray_error();
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 64'h1234_5678_9ABC_DEF0;
        step();
        lsu_valid = 1'b0;
        n_cmp++; if ({wr_en_out, wr_rd_out, wr_data_out} !== {1'b1, 5'd9, 64'h1234_5678_9ABC_DEF0}) begin
            n_fail++; $display("FAIL err_write got en=%b rd=%0d data=%h want 1/9/123456789abcdef0", wr_en_out, wr_rd_out, wr_data_out);
        end
        n_cmp++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL err_early got %b want 0", err_out); end
        step();
        n_cmp++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err_out); end
        step(); step();
        n_cmp++; if ({err_out, busy_out} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL err_sticky got err=%b busy=%h want 1/0", err_out, busy_out); end
    endtask

    task automatic test_set_wins();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_uses_rd = 1'b1; issue_rd = 5'd7;
        #1;
        n_cmp++; if ({wr_en_out, wr_rd_out, issue_ready} !== {1'b1, 5'd7, 1'b1}) begin
            n_fail++; $display("FAIL sw_pre got en=%b rd=%0d ready=%b want 1/7/1", wr_en_out, wr_rd_out, issue_ready);
        end
        step();
        issue_valid = 1'b0;
        n_cmp++; if (busy_out !== 32'h0000_0080) begin n_fail++; $display("FAIL sw_busy7 got %h want 00000080", busy_out); end
        n_cmp++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL sw_err got %b want 1", err_out); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({err_out, busy_out} !== 33'h0) begin n_fail++; $display("FAIL sw_reset got err=%b busy=%h want 0/0", err_out, busy_out); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_arbitration();
        test_x0_writeback();
        test_stray_error();
        test_set_wins();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
